sdram_port_arbiter: RTL and testbench

//  Shares the single-master SDRAM transaction port (stb/we/sel/adr/out/dat/ack) between

---
 rtl/sdram_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM transaction port between three requesters
// (0 = CPU, 1 = disk DMA, 2 = auxiliary), with one transaction in flight at a time.
// Ports:
//   clk_p, rst_n                         clock, asynchronous active-low reset
//   m_stb/m_we/m_sel/m_adr/m_out         packed per-port request buses (port i in slice i)
//   m_dat, m_ack                         shared read data, per-port acknowledge
//   sdram_ready                          SDRAM initialisation done
//   sdram_stb/we/sel/adr/out             transaction towards the SDRAM
//   sdram_dat, sdram_ack                 reply from the SDRAM
//   grant                                owning port, 2'd3 = none
//   timeout_err                          sticky watchdog flag
module sdram_port_arbiter #(
   parameter bit          RR      = 1'b1,
   parameter int unsigned TIMEOUT = 255,
   localparam int unsigned NP     = 3,
   localparam int unsigned SEL_W  = 2,
   localparam int unsigned ADR_W  = 21,
   localparam int unsigned DAT_W  = 16,
   localparam int unsigned CNT_W  = 16
) (
   input  logic                  clk_p,
   input  logic                  rst_n,
   input  logic [NP-1:0]         m_stb,
   input  logic [NP-1:0]         m_we,
   input  logic [NP*SEL_W-1:0]   m_sel,
   input  logic [NP*ADR_W-1:0]   m_adr,
   input  logic [NP*DAT_W-1:0]   m_out,
   output logic [DAT_W-1:0]      m_dat,
   output logic [NP-1:0]         m_ack,
   input  logic                  sdram_ready,
   output logic                  sdram_stb,
   output logic                  sdram_we,
   output logic [SEL_W-1:0]      sdram_sel,
   output logic [ADR_W-1:0]      sdram_adr,
   output logic [DAT_W-1:0]      sdram_out,
   input  logic [DAT_W-1:0]      sdram_dat,
   input  logic                  sdram_ack,
   output logic [1:0]            grant,
   output logic                  timeout_err
);

   localparam logic [1:0]       NONE    = 2'd3;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD, S_GAP} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          last_q, last_d;
   logic                abort_q, abort_d;

   logic [DAT_W-1:0]    m_dat_d;
   logic [NP-1:0]       m_ack_d;
   logic                stb_d, we_d, terr_d;
   logic [SEL_W-1:0]    sel_d;
   logic [ADR_W-1:0]    adr_d;
   logic [DAT_W-1:0]    out_d;
   logic [1:0]          grant_d;

   logic                win_vld_c;
   logic [1:0]          win_idx_c, cand_c;
   logic                start_c, done_c, own_stb_c, keep_c;
   logic [SEL_W-1:0]    sel_a_c [NP];
   logic [ADR_W-1:0]    adr_a_c [NP];
   logic [DAT_W-1:0]    out_a_c [NP];

   function automatic logic [1:0] nxt_port(input logic [1:0] p);
      return (p >= 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Unpack the per-port request buses
   always_comb begin
      for (int i = 0; i < NP; i++) begin
         sel_a_c[i] = m_sel[i*SEL_W +: SEL_W];
         adr_a_c[i] = m_adr[i*ADR_W +: ADR_W];
         out_a_c[i] = m_out[i*DAT_W +: DAT_W];
      end
   end

   // Winner search: RR starts after the last granted port, fixed priority starts at 0
   always_comb begin
      win_vld_c = 1'b0;
      win_idx_c = 2'd0;
      cand_c    = RR ? nxt_port(last_q) : 2'd0;
      for (int k = 0; k < NP; k++) begin
         if (!win_vld_c && m_stb[cand_c]) begin
            win_vld_c = 1'b1;
            win_idx_c = cand_c;
         end
         cand_c = nxt_port(cand_c);
      end
   end

   assign start_c   = sdram_ready && win_vld_c;
   assign done_c    = sdram_ack || (cnt_q == TO_LAST);
   assign own_stb_c = m_stb[grant];
   // A master that dropped its strobe at any point in BUSY gets no acknowledge
   assign keep_c    = own_stb_c && !abort_q;

   // State register
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_c) state_d = S_BUSY;
         S_BUSY: if (done_c)  state_d = keep_c ? S_HOLD : S_GAP;
         S_HOLD: if (!own_stb_c) state_d = S_GAP;
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      m_dat_d = m_dat;
      m_ack_d = m_ack;
      stb_d   = sdram_stb;
      we_d    = sdram_we;
      sel_d   = sdram_sel;
      adr_d   = sdram_adr;
      out_d   = sdram_out;
      grant_d = grant;
      terr_d  = timeout_err;
      cnt_d   = cnt_q;
      last_d  = last_q;
      abort_d = abort_q;
      case (state_q)
         S_IDLE: begin
            if (start_c) begin
               stb_d   = 1'b1;
               grant_d = win_idx_c;
               we_d    = m_we[win_idx_c];
               sel_d   = sel_a_c[win_idx_c];
               adr_d   = adr_a_c[win_idx_c];
               out_d   = out_a_c[win_idx_c];
               cnt_d   = '0;
               abort_d = 1'b0;
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!own_stb_c) abort_d = 1'b1;
            if (done_c) begin
               stb_d   = 1'b0;
               last_d  = grant;
               m_dat_d = sdram_ack ? sdram_dat : '0;
               if (!sdram_ack) terr_d = 1'b1;
               if (keep_c) m_ack_d = NP'(1) << grant;
               else        grant_d = NONE;
            end
         end
         S_HOLD: begin
            if (!own_stb_c) begin
               m_ack_d = '0;
               grant_d = NONE;
            end
         end
         default: ;
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         m_dat       <= '0;
         m_ack       <= '0;
         sdram_stb   <= 1'b0;
         sdram_we    <= 1'b0;
         sdram_sel   <= '0;
         sdram_adr   <= '0;
         sdram_out   <= '0;
         grant       <= NONE;
         timeout_err <= 1'b0;
         cnt_q       <= '0;
         last_q      <= 2'd2;
         abort_q     <= 1'b0;
      end else begin
         m_dat       <= m_dat_d;
         m_ack       <= m_ack_d;
         sdram_stb   <= stb_d;
         sdram_we    <= we_d;
         sdram_sel   <= sel_d;
         sdram_adr   <= adr_d;
         sdram_out   <= out_d;
         grant       <= grant_d;
         timeout_err <= terr_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         abort_q     <= abort_d;
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: a round-robin and a fixed-priority instance share the
// stimulus; use_fp selects which one is observed.
module tb_sdram_port_arbiter;

   logic        clk_p;
   logic        rst_n;
   logic [2:0]  m_stb, m_we;
   logic [5:0]  m_sel;
   logic [62:0] m_adr;
   logic [47:0] m_out;
   logic        sdram_ready, sdram_ack;
   logic [15:0] sdram_dat;

   logic [15:0] r_m_dat, f_m_dat;
   logic [2:0]  r_m_ack, f_m_ack;
   logic        r_stb, f_stb, r_we, f_we, r_terr, f_terr;
   logic [1:0]  r_sel, f_sel, r_grant, f_grant;
   logic [20:0] r_adr, f_adr;
   logic [15:0] r_out, f_out;

   logic        use_fp;
   logic [15:0] v_m_dat;
   logic [2:0]  v_m_ack;
   logic        v_stb, v_we, v_terr;
   logic [1:0]  v_sel, v_grant;
   logic [20:0] v_adr;
   logic [15:0] v_out;

   int checks, errors;
   logic [1:0] gseq[$];

   sdram_port_arbiter #(.RR(1'b1), .TIMEOUT(8)) u_rr (
      .clk_p(clk_p), .rst_n(rst_n), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
      .m_adr(m_adr), .m_out(m_out), .m_dat(r_m_dat), .m_ack(r_m_ack),
      .sdram_ready(sdram_ready), .sdram_stb(r_stb), .sdram_we(r_we), .sdram_sel(r_sel),
      .sdram_adr(r_adr), .sdram_out(r_out), .sdram_dat(sdram_dat), .sdram_ack(sdram_ack),
      .grant(r_grant), .timeout_err(r_terr));

   sdram_port_arbiter #(.RR(1'b0), .TIMEOUT(8)) u_fp (
      .clk_p(clk_p), .rst_n(rst_n), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
      .m_adr(m_adr), .m_out(m_out), .m_dat(f_m_dat), .m_ack(f_m_ack),
      .sdram_ready(sdram_ready), .sdram_stb(f_stb), .sdram_we(f_we), .sdram_sel(f_sel),
      .sdram_adr(f_adr), .sdram_out(f_out), .sdram_dat(sdram_dat), .sdram_ack(sdram_ack),
      .grant(f_grant), .timeout_err(f_terr));

   assign v_m_dat = use_fp ? f_m_dat : r_m_dat;
   assign v_m_ack = use_fp ? f_m_ack : r_m_ack;
   assign v_stb   = use_fp ? f_stb   : r_stb;
   assign v_we    = use_fp ? f_we    : r_we;
   assign v_sel   = use_fp ? f_sel   : r_sel;
   assign v_adr   = use_fp ? f_adr   : r_adr;
   assign v_out   = use_fp ? f_out   : r_out;
   assign v_grant = use_fp ? f_grant : r_grant;
   assign v_terr  = use_fp ? f_terr  : r_terr;

   initial clk_p = 1'b0;
   always #5 clk_p = ~clk_p;

   typedef struct {
      logic [2:0]  stb;
      logic        rdy;
      logic        ack;
      logic [15:0] dat;
      logic        e_stb;
      logic [1:0]  e_grant;
      logic [2:0]  e_ack;
      logic        cd;
      logic [15:0] e_dat;
   } vec_t;

   vec_t tbl[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_p);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk_p);
      rst_n = 1'b0;
      m_stb = '0; sdram_ack = 1'b0; sdram_ready = 1'b0; sdram_dat = '0;
      repeat (2) @(negedge clk_p);
      rst_n = 1'b1;
   endtask

   task automatic set_port(input int i, input logic we, input logic [1:0] sel,
                           input logic [20:0] adr, input logic [15:0] dat);
      m_we[i] = we;
      m_sel[2*i +: 2] = sel;
      m_adr[21*i +: 21] = adr;
      m_out[16*i +: 16] = dat;
   endtask

   // Expected winner from the request set and the last grant
   function automatic logic [1:0] pick(input logic [2:0] req, input logic [1:0] last, input bit rr);
      int unsigned p;
      for (int unsigned k = 0; k < 3; k++) begin
         p = rr ? (32'(last) + 1 + k) % 3 : k;
         if (req[2'(p)]) return 2'(p);
      end
      return 2'd3;
   endfunction

   // Ports in mask re-request as soon as their ack is seen; SDRAM acks on the 2nd BUSY sample
   task automatic run_cont(input bit fp, input logic [2:0] mask, input int ncyc);
      int  hi, low_run;
      bit  had, prev_s;
      use_fp = fp;
      do_reset();
      gseq.delete();
      sdram_ready = 1'b1; m_stb = mask;
      hi = 0; low_run = 0; had = 0; prev_s = 0;
      for (int c = 0; c < ncyc; c++) begin
         tick();
         if (v_stb && !prev_s) begin
            gseq.push_back(v_grant);
            if (had) chk("cont_gap", 32'(low_run >= 2), 32'(1));
            had = 1;
         end
         low_run = v_stb ? 0 : low_run + 1;
         prev_s = v_stb;
         chk("cont_ack_onehot", 32'($countones(v_m_ack) <= 1), 32'(1));
         m_stb = mask & ~v_m_ack;
         hi = v_stb ? hi + 1 : 0;
         sdram_ack = (hi == 2);
         sdram_dat = 16'($urandom);
      end
      sdram_ack = 1'b0; m_stb = '0;
   endtask

   // Random masters and SDRAM against a transaction-level expectation
   task automatic run_random(input bit fp, input int ncyc);
      logic [2:0]  seen_stb;
      logic        seen_rdy, prev_s;
      logic [1:0]  last, cur, expg;
      logic [15:0] edat;
      int low_run, rwait, total, g;
      bit had, sent, pend;
      int idle[3], hold[3], acks[3];
      use_fp = fp;
      do_reset();
      sdram_ready = 1'b1;
      last = 2'd2; cur = 2'd0; prev_s = 0; low_run = 0; rwait = 0; total = 0;
      had = 0; sent = 0; pend = 0; edat = '0;
      for (int i = 0; i < 3; i++) begin idle[i] = i; hold[i] = 0; acks[i] = 0; end
      for (int c = 0; c < ncyc; c++) begin
         seen_stb = m_stb; seen_rdy = sdram_ready;
         tick();
         if (v_stb && !prev_s) begin
            expg = pick(seen_stb, last, !fp);
            g = int'(expg);
            chk("rnd_grant", 32'(v_grant), 32'(expg));
            chk("rnd_ready", 32'(seen_rdy), 32'(1));
            if (g < 3) begin
               chk("rnd_adr", 32'(v_adr), 32'(m_adr[21*g +: 21]));
               chk("rnd_sel", 32'(v_sel), 32'(m_sel[2*g +: 2]));
               chk("rnd_we",  32'(v_we),  32'(m_we[g]));
               chk("rnd_out", 32'(v_out), 32'(m_out[16*g +: 16]));
            end
            if (had) chk("rnd_gap", 32'(low_run >= 2), 32'(1));
            had = 1; last = expg; cur = expg;
            rwait = $urandom_range(0, 4); sent = 0;
         end
         low_run = v_stb ? 0 : low_run + 1;
         prev_s = v_stb;
         if (pend) begin
            chk("rnd_ack", 32'(v_m_ack), 32'(3'b001 << cur));
            chk("rnd_dat", 32'(v_m_dat), 32'(edat));
            acks[cur]++; total++;
            pend = 0;
         end
         chk("rnd_ack_onehot", 32'($countones(v_m_ack) <= 1), 32'(1));
         chk("rnd_terr", 32'(v_terr), 32'(0));
         sdram_ack = 1'b0;
         if (v_stb && !sent) begin
            if (rwait == 0) begin
               edat = 16'($urandom);
               sdram_dat = edat; sdram_ack = 1'b1; sent = 1; pend = 1;
            end else rwait--;
         end else sdram_dat = 16'($urandom);
         for (int i = 0; i < 3; i++) begin
            if (m_stb[i]) begin
               if (v_m_ack[i]) begin
                  if (hold[i] > 0) hold[i]--;
                  else begin m_stb[i] = 1'b0; idle[i] = $urandom_range(0, 3); end
               end
            end else if (idle[i] > 0) idle[i]--;
            else begin
               set_port(i, 1'($urandom), 2'($urandom), 21'($urandom), 16'($urandom));
               m_stb[i] = 1'b1; hold[i] = $urandom_range(0, 1);
            end
         end
         sdram_ready = ($urandom_range(0, 7) != 0);
      end
      chk("rnd_progress", 32'(total >= ncyc / 16), 32'(1));
      if (!fp) for (int i = 0; i < 3; i++) chk("rnd_port_served", 32'(acks[i] > 0), 32'(1));
      sdram_ack = 1'b0; m_stb = '0;
   endtask

   initial begin
      int n;
      bit done;
      checks = 0; errors = 0; use_fp = 1'b0;
      rst_n = 1'b0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_out = '0;
      sdram_ready = 1'b0; sdram_ack = 1'b0; sdram_dat = '0;

      tbl[0]  = '{3'b001, 1, 0, 16'h0000, 1, 2'd0, 3'b000, 0, 16'h0000};
      tbl[1]  = '{3'b001, 1, 0, 16'h0000, 1, 2'd0, 3'b000, 0, 16'h0000};
      tbl[2]  = '{3'b001, 1, 0, 16'h0000, 1, 2'd0, 3'b000, 0, 16'h0000};
      tbl[3]  = '{3'b001, 1, 1, 16'h1234, 0, 2'd0, 3'b001, 1, 16'h1234};
      tbl[4]  = '{3'b001, 1, 0, 16'h0000, 0, 2'd0, 3'b001, 1, 16'h1234};
      tbl[5]  = '{3'b000, 1, 0, 16'h0000, 0, 2'd3, 3'b000, 0, 16'h0000};
      tbl[6]  = '{3'b000, 1, 0, 16'h0000, 0, 2'd3, 3'b000, 0, 16'h0000};
      tbl[7]  = '{3'b001, 1, 0, 16'h0000, 1, 2'd0, 3'b000, 0, 16'h0000};
      tbl[8]  = '{3'b001, 1, 1, 16'hBEEF, 0, 2'd0, 3'b001, 1, 16'hBEEF};
      tbl[9]  = '{3'b010, 1, 0, 16'h0000, 0, 2'd3, 3'b000, 0, 16'h0000};
      tbl[10] = '{3'b010, 1, 0, 16'h0000, 0, 2'd3, 3'b000, 0, 16'h0000};
      tbl[11] = '{3'b010, 1, 0, 16'h0000, 1, 2'd1, 3'b000, 0, 16'h0000};
      tbl[12] = '{3'b010, 0, 1, 16'h5A5A, 0, 2'd1, 3'b010, 1, 16'h5A5A};
      tbl[13] = '{3'b000, 0, 0, 16'h0000, 0, 2'd3, 3'b000, 0, 16'h0000};
      tbl[14] = '{3'b100, 0, 0, 16'h0000, 0, 2'd3, 3'b000, 0, 16'h0000};
      tbl[15] = '{3'b100, 0, 0, 16'h0000, 0, 2'd3, 3'b000, 0, 16'h0000};
      tbl[16] = '{3'b100, 1, 0, 16'h0000, 1, 2'd2, 3'b000, 0, 16'h0000};
      tbl[17] = '{3'b000, 1, 0, 16'h0000, 1, 2'd2, 3'b000, 0, 16'h0000};
      tbl[18] = '{3'b000, 1, 1, 16'h7777, 0, 2'd3, 3'b000, 0, 16'h0000};
      tbl[19] = '{3'b000, 1, 0, 16'h0000, 0, 2'd3, 3'b000, 0, 16'h0000};

      // Reset values
      do_reset();
      chk("rst_grant", 32'(v_grant), 32'(2'd3));
      chk("rst_stb",   32'(v_stb),   32'(0));
      chk("rst_ack",   32'(v_m_ack), 32'(0));
      chk("rst_dat",   32'(v_m_dat), 32'(0));
      chk("rst_adr",   32'(v_adr),   32'(0));
      chk("rst_terr",  32'(v_terr),  32'(0));

      // Table: single write, re-grant, GAP length, ready gating, abort
      set_port(0, 1'b1, 2'b01, 21'h000100, 16'hA5A5);
      set_port(1, 1'b0, 2'b10, 21'h1ABCDE, 16'h1111);
      set_port(2, 1'b1, 2'b11, 21'h0F0F0F, 16'h2222);
      for (int k = 0; k < 20; k++) begin
         m_stb = tbl[k].stb; sdram_ready = tbl[k].rdy;
         sdram_ack = tbl[k].ack; sdram_dat = tbl[k].dat;
         tick();
         chk($sformatf("tbl%0d_stb", k),   32'(v_stb),   32'(tbl[k].e_stb));
         chk($sformatf("tbl%0d_grant", k), 32'(v_grant), 32'(tbl[k].e_grant));
         chk($sformatf("tbl%0d_ack", k),   32'(v_m_ack), 32'(tbl[k].e_ack));
         chk($sformatf("tbl%0d_terr", k),  32'(v_terr),  32'(0));
         if (tbl[k].cd) chk($sformatf("tbl%0d_dat", k), 32'(v_m_dat), 32'(tbl[k].e_dat));
         if (k == 0) begin
            chk("wr_we",  32'(v_we),  32'(1));
            chk("wr_sel", 32'(v_sel), 32'(2'b01));
            chk("wr_adr", 32'(v_adr), 32'(21'h000100));
            chk("wr_out", 32'(v_out), 32'(16'hA5A5));
         end
      end
      sdram_ack = 1'b0;

      // Round-robin with all ports requesting
      run_cont(1'b0, 3'b111, 60);
      chk("rr_count", 32'(gseq.size() >= 6), 32'(1));
      for (int k = 0; k < 6 && k < gseq.size(); k++)
         chk($sformatf("rr_seq%0d", k), 32'(gseq[k]), 32'(k % 3));

      // Fixed priority: port 2 starved while port 0 requests
      run_cont(1'b1, 3'b101, 60);
      chk("fp_count", 32'(gseq.size() >= 4), 32'(1));
      foreach (gseq[k]) chk($sformatf("fp_seq%0d", k), 32'(gseq[k]), 32'(2'd0));

      // sdram_ready low holds requests
      use_fp = 1'b0;
      do_reset();
      m_stb = 3'b010;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("notready_stb", 32'(v_stb), 32'(0));
      end
      sdram_ready = 1'b1;
      tick();
      chk("ready_grant", 32'(v_grant), 32'(2'd1));
      chk("ready_stb",   32'(v_stb),   32'(1));

      // Watchdog timeout
      do_reset();
      sdram_ready = 1'b1; sdram_dat = 16'hFFFF; m_stb = 3'b010;
      n = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         tick();
         if (v_stb) n++;
         else if (n > 0) done = 1;
      end
      chk("to_ended",   32'(done),    32'(1));
      chk("to_len",     32'(n),       32'(8));
      chk("to_ack",     32'(v_m_ack), 32'(3'b010));
      chk("to_dat",     32'(v_m_dat), 32'(0));
      chk("to_terr",    32'(v_terr),  32'(1));
      m_stb = '0;
      tick(); tick();
      chk("to_grant_free", 32'(v_grant), 32'(2'd3));
      chk("to_sticky1",    32'(v_terr),  32'(1));
      m_stb = 3'b001; sdram_dat = 16'h4242;
      tick();
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      chk("to_after_ack", 32'(v_m_ack), 32'(3'b001));
      chk("to_after_dat", 32'(v_m_dat), 32'(16'h4242));
      chk("to_sticky2",   32'(v_terr),  32'(1));
      m_stb = '0;
      do_reset();
      chk("to_reset_clr", 32'(v_terr), 32'(0));

      // Abort by port 1, port 0 waiting
      sdram_ready = 1'b1; m_stb = 3'b010;
      tick();
      chk("ab_stb",   32'(v_stb),   32'(1));
      chk("ab_grant", 32'(v_grant), 32'(2'd1));
      m_stb = 3'b001;
      tick(); tick();
      chk("ab_busy_stb", 32'(v_stb),   32'(1));
      chk("ab_busy_ack", 32'(v_m_ack), 32'(0));
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      chk("ab_gap_stb",   32'(v_stb),   32'(0));
      chk("ab_gap_ack",   32'(v_m_ack), 32'(0));
      chk("ab_gap_grant", 32'(v_grant), 32'(2'd3));
      tick();
      chk("ab_idle_stb", 32'(v_stb),   32'(0));
      chk("ab_idle_ack", 32'(v_m_ack), 32'(0));
      tick();
      chk("ab_next_grant", 32'(v_grant), 32'(2'd0));
      chk("ab_next_stb",   32'(v_stb),   32'(1));

      // Asynchronous reset mid-BUSY
      #2 rst_n = 1'b0;
      #1;
      chk("ar_stb",   32'(v_stb),   32'(0));
      chk("ar_grant", 32'(v_grant), 32'(2'd3));
      chk("ar_adr",   32'(v_adr),   32'(0));
      chk("ar_we",    32'(v_we),    32'(0));
      m_stb = '0;
      do_reset();

      // Randomised traffic on both arbiters
      run_random(1'b0, 800);
      run_random(1'b1, 800);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
